// File: rtl/irq_ctrl_pkg.sv
// Shared constants and register indices for the irq_ctrl interrupt controller.
package irq_ctrl_pkg;

   localparam int unsigned NLINES          = 32;
   localparam int unsigned ID_W            = 5;
   localparam int unsigned ADDR_W          = 3;
   localparam int unsigned CAUSE_VALID_BIT = 31;

   typedef enum logic [ADDR_W-1:0] {
      PEND  = 3'd0,
      ENA   = 3'd1,
      RAW   = 3'd2,
      CAUSE = 3'd3,
      SET   = 3'd4,
      MODE  = 3'd5,
      CTRL  = 3'd6,
      RSVD  = 3'd7
   } reg_idx_e;

   // Bit mask of the lines actually in use (lines at n and above read as zero).
   function automatic logic [NLINES-1:0] line_mask(input int unsigned n);
      logic [NLINES-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < NLINES; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Register bus shared by the timer, GPIO and interrupt controller slaves.
interface irq_ctrl_if
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32
);
   logic              cs;
   logic              wen;
   logic [ADDR_W-1:0] addr;
   logic [WIDTH-1:0]  din;
   logic [WIDTH-1:0]  dout;

   modport master (output cs, wen, addr, din, input dout);
   modport slave  (input cs, wen, addr, din, output dout);
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set and its index.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0]    req,
   output logic            any,
   output logic [ID_W-1:0] idx
);

   // Scan downward so the lowest set index is the last one written.
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req[i]) begin
            any = 1'b1;
            idx = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller with edge/level pending latches and a registered request.
// Define IRQ_CTRL_SYNC_EN to add a 2-flop input synchronizer ahead of the raw sample.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NIRQ  = 32
) (
   input  logic              clk,
   input  logic              reset,
   irq_ctrl_if.slave         bus,
   input  logic [NLINES-1:0] irqs,
   output logic              irq,
   output logic [ID_W-1:0]   irq_id
);

   localparam logic [NLINES-1:0] LINE_MASK = line_mask(NIRQ);
`ifdef IRQ_CTRL_SYNC_EN
   localparam int unsigned VLD_W = 4;
`else
   localparam int unsigned VLD_W = 2;
`endif

   logic [NLINES-1:0] src;
   logic [NLINES-1:0] raw_q, raw_d, pend_q, ena_q, mode_q;
   logic              gie_q;
   logic [VLD_W-1:0]  vld_q;
   logic [NLINES-1:0] set_v, clr_v, cause_clr, act, wdata, rdata;
   logic              wr, edge_ok, act_any, valid;
   logic [ID_W-1:0]   win_id;
   reg_idx_e          sel;

`ifdef IRQ_CTRL_SYNC_EN
   logic [NLINES-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= irqs;
         sync2_q <= sync1_q;
      end
   end

   assign src = sync2_q;
`else
   assign src = irqs;
`endif

   assign wr    = bus.cs & bus.wen;
   assign sel   = reg_idx_e'(bus.addr);
   assign wdata = bus.din[NLINES-1:0];

   // Edge detection stays off until raw_d holds a real post-reset sample.
   assign edge_ok = vld_q[VLD_W-1];

   assign set_v = ((mode_q & raw_q & ~raw_d & {NLINES{edge_ok}}) |
                   (~mode_q & raw_q) |
                   ((wr && sel == SET) ? wdata : '0)) & LINE_MASK;

   assign cause_clr = (wr && sel == CAUSE && irq) ? (NLINES'(1) << irq_id) : '0;
   assign clr_v     = ((wr && sel == PEND) ? wdata : '0) | cause_clr;

   assign act   = pend_q & ena_q;
   assign valid = gie_q & act_any;

   irq_prio_enc #(.N(NLINES)) u_prio (
      .req (act),
      .any (act_any),
      .idx (win_id)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         raw_q  <= '0;
         raw_d  <= '0;
         vld_q  <= '0;
         pend_q <= '0;
         ena_q  <= '0;
         mode_q <= '0;
         gie_q  <= 1'b0;
         irq    <= 1'b0;
         irq_id <= '0;
      end else begin
         raw_q  <= src & LINE_MASK;
         raw_d  <= raw_q;
         vld_q  <= {vld_q[VLD_W-2:0], 1'b1};
         pend_q <= ((pend_q & ~clr_v) | set_v) & LINE_MASK;
         if (wr && sel == ENA)  ena_q  <= wdata & LINE_MASK;
         if (wr && sel == MODE) mode_q <= wdata & LINE_MASK;
         if (wr && sel == CTRL) gie_q  <= wdata[0];
         irq    <= valid;
         irq_id <= valid ? win_id : '0;
      end
   end

   // CAUSE reflects the registered request so software sees what the CPU sees.
   always_comb begin
      rdata = '0;
      if (bus.cs) begin
         case (sel)
            PEND:    rdata = pend_q;
            ENA:     rdata = ena_q;
            RAW:     rdata = raw_q;
            CAUSE: begin
               rdata[CAUSE_VALID_BIT] = irq;
               rdata[ID_W-1:0]        = irq_id;
            end
            MODE:    rdata = mode_q;
            CTRL:    rdata[0] = gie_q;
            default: rdata = '0;
         endcase
      end
   end

   assign bus.dout = WIDTH'(rdata);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomized bench for irq_ctrl against a per-line reference model.
module tb_irq_ctrl;
   import irq_ctrl_pkg::*;

   localparam int unsigned NIRQ = 32;
`ifdef IRQ_CTRL_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] irqs;
   logic        irq;
   logic [4:0]  irq_id;

   irq_ctrl_if #(.WIDTH(32)) bus ();

   irq_ctrl #(.WIDTH(32), .NIRQ(NIRQ)) dut (
      .clk    (clk),
      .reset  (reset),
      .bus    (bus.slave),
      .irqs   (irqs),
      .irq    (irq),
      .irq_id (irq_id)
   );

   always #10 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: state after the most recent edge, plus the input history.
   logic [31:0] m_pend, m_ena, m_mode;
   logic        m_gie, m_irq;
   logic [4:0]  m_id;
   int          n;
   logic [31:0] hist[$];

   function automatic logic [31:0] lmask();
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 32; i++) if (i < int'(NIRQ)) m[i] = 1'b1;
      return m;
   endfunction

   // irqs value that was driven before edge k (k counted from reset release).
   function automatic logic [31:0] h(input int k);
      return (k >= 1) ? hist[k] : 32'h0;
   endfunction

   function automatic logic [31:0] mread(input logic [2:0] a);
      case (a)
         3'd0:    return m_pend;
         3'd1:    return m_ena;
         3'd2:    return h(n - S);
         3'd3:    return {m_irq, 26'h0, m_id};
         3'd5:    return m_mode;
         3'd6:    return {31'h0, m_gie};
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic commit(input logic [31:0] iv, input logic w, input logic [2:0] a,
                         input logic [31:0] d);
      logic [31:0] lvl, prev, np;
      logic        eok, nirq, s, c;
      logic [4:0]  nid;
      if (reset) begin
         m_pend = 0; m_ena = 0; m_mode = 0; m_gie = 0; m_irq = 0; m_id = 0;
         n = 0;
         hist.delete();
         hist.push_back(32'h0);
      end else begin
         n++;
         hist.push_back(iv & lmask());
         lvl  = h(n - 1 - S);
         prev = h(n - 2 - S);
         eok  = (n - 2 - S) >= 1;
         nirq = 1'b0;
         nid  = 5'd0;
         for (int i = 0; i < 32; i++) begin
            if (!nirq && m_gie && m_pend[i] && m_ena[i]) begin
               nirq = 1'b1;
               nid  = 5'(i);
            end
         end
         for (int i = 0; i < 32; i++) begin
            s = (m_mode[i] ? (eok && lvl[i] && !prev[i]) : lvl[i]) || (w && a == 3'd4 && d[i]);
            c = (w && a == 3'd0 && d[i]) || (w && a == 3'd3 && m_irq && m_id == 5'(i));
            if (s)      np[i] = 1'b1;
            else if (c) np[i] = 1'b0;
            else        np[i] = m_pend[i];
         end
         if (w && a == 3'd1) m_ena  = d & lmask();
         if (w && a == 3'd5) m_mode = d & lmask();
         if (w && a == 3'd6) m_gie  = d[0];
         m_pend = np & lmask();
         m_irq  = nirq;
         m_id   = nid;
      end
   endtask

   task automatic check_all();
      chk("irq", 32'(irq), 32'(m_irq));
      chk("irq_id", 32'(irq_id), 32'(m_id));
      for (int k = 0; k < 8; k++) begin
         bus.cs = 1'b1; bus.wen = 1'b0; bus.addr = 3'(k);
         #1;
         chk($sformatf("read%0d", k), bus.dout, mread(3'(k)));
      end
      bus.cs = 1'b0;
      #1;
      chk("read_nocs", bus.dout, 32'h0);
   endtask

   task automatic tick(input logic [31:0] iv, input logic w, input logic [2:0] a,
                       input logic [31:0] d);
      irqs = iv; bus.cs = w; bus.wen = w; bus.addr = a; bus.din = d;
      @(posedge clk);
      #1;
      commit(iv, w, a, d);
      check_all();
   endtask

   task automatic idle(input logic [31:0] iv, input int k);
      for (int i = 0; i < k; i++) tick(iv, 1'b0, 3'd0, 32'h0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] iv);
      tick(iv, 1'b1, a, d);
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] v);
      bus.cs = 1'b1; bus.wen = 1'b0; bus.addr = a;
      #1;
      v = bus.dout;
      bus.cs = 1'b0;
   endtask

   task automatic do_reset(input logic [31:0] iv);
      reset = 1'b1;
      idle(iv, 2);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] v, iv, d;
      logic        w;
      logic [2:0]  a;
      reset = 1'b1; irqs = 0;
      bus.cs = 0; bus.wen = 0; bus.addr = 0; bus.din = 0;
      n = 0;
      hist.push_back(32'h0);

      // 1: everything reads zero out of reset
      do_reset(32'h0);
      for (int k = 0; k < 8; k++) begin
         rd(3'(k), v);
         chk($sformatf("t1_reg%0d", k), v, 32'h0);
      end
      chk("t1_irq", 32'(irq), 32'h0);
      chk("t1_irq_id", 32'(irq_id), 32'h0);

      // edge line already high at reset release must not latch
      do_reset(32'hFFFF_FFFF);
      wr(MODE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      idle(32'hFFFF_FFFF, 3);
      rd(PEND, v);
      chk("t_rst_noedge", v, 32'h0);
      do_reset(32'h0);
      idle(32'h0, 4);

      // 2: level line 0, latency to PEND and irq
      wr(ENA, 32'h1, 32'h0);
      wr(CTRL, 32'h1, 32'h0);
      idle(32'h1, 1 + S);
      rd(PEND, v);
      chk("t2_pend_early", v, 32'h0);
      idle(32'h1, 1);
      rd(PEND, v);
      chk("t2_pend", v, 32'h1);
      chk("t2_irq_early", 32'(irq), 32'h0);
      idle(32'h1, 1);
      chk("t2_irq", 32'(irq), 32'h1);
      chk("t2_irq_id", 32'(irq_id), 32'h0);
      rd(CAUSE, v);
      chk("t2_cause", v, 32'h8000_0000);

      // 3: two edge lines pulsed together, acknowledged through CAUSE
      idle(32'h0, 2 + S);
      wr(PEND, 32'h1, 32'h0);
      wr(MODE, 32'hFFFF_FFFF, 32'h0);
      wr(ENA, 32'h30, 32'h0);
      tick(32'h30, 1'b0, 3'd0, 32'h0);
      idle(32'h0, 1 + S);
      rd(PEND, v);
      chk("t3_pend", v, 32'h30);
      idle(32'h0, 1);
      chk("t3_id4", 32'(irq_id), 32'd4);
      wr(CAUSE, 32'h0, 32'h0);
      rd(PEND, v);
      chk("t3_pend_ack1", v, 32'h20);
      idle(32'h0, 1);
      chk("t3_id5", 32'(irq_id), 32'd5);
      wr(CAUSE, 32'h0, 32'h0);
      chk("t3_irq_hold", 32'(irq), 32'h1);
      idle(32'h0, 1);
      chk("t3_irq_drop", 32'(irq), 32'h0);

      // 4: held level line survives W1C until released
      wr(MODE, 32'h0, 32'h4);
      wr(ENA, 32'h4, 32'h4);
      idle(32'h4, 3 + S);
      chk("t4_irq", 32'(irq), 32'h1);
      chk("t4_id", 32'(irq_id), 32'd2);
      wr(PEND, 32'h4, 32'h4);
      rd(PEND, v);
      chk("t4_pend_held", v, 32'h4);
      idle(32'h4, 2);
      chk("t4_irq_held", 32'(irq), 32'h1);
      idle(32'h0, 2 + S);
      wr(PEND, 32'h4, 32'h0);
      rd(PEND, v);
      chk("t4_pend_clr", v, 32'h0);
      idle(32'h0, 1);
      chk("t4_irq_drop", 32'(irq), 32'h0);

      // 5: W1C colliding with a new edge keeps the event
      wr(MODE, 32'hFFFF_FFFF, 32'h0);
      wr(ENA, 32'h8, 32'h0);
      idle(32'h0, 2);
      idle(32'h8, 1 + S);
      wr(PEND, 32'h8, 32'h8);
      rd(PEND, v);
      chk("t5_set_wins", v, 32'h8);

      // 6: SET register and the global enable
      wr(CTRL, 32'h0, 32'h0);
      wr(ENA, 32'h8000_0000, 32'h0);
      wr(PEND, 32'hFFFF_FFFF, 32'h0);
      wr(SET, 32'h8000_0000, 32'h0);
      rd(PEND, v);
      chk("t6_pend", v, 32'h8000_0000);
      idle(32'h0, 1);
      chk("t6_irq_gie0", 32'(irq), 32'h0);
      wr(CTRL, 32'h1, 32'h0);
      idle(32'h0, 1);
      chk("t6_irq", 32'(irq), 32'h1);
      chk("t6_id31", 32'(irq_id), 32'd31);

      // randomized traffic with one mid-run reset
      iv = 32'h0;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset($urandom);
         if ($urandom_range(0, 3) == 0) iv = $urandom & $urandom;
         w = ($urandom_range(0, 2) == 0);
         a = 3'($urandom_range(0, 7));
         d = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & $urandom);
         tick(iv, w, a, d);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
